// File: rtl/pzcorebus_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : pzcorebus_gate_controller
// Purpose  : Blocks, drains and then switches a corebus gate between the
//            master path (open) and the dummy-slave path (closed).
//            Optional drain timeout: define PZCOREBUS_GATE_CONTROLLER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pzcorebus_gate_controller #(
   parameter int  MAX_NON_POSTED = 16,
   parameter int  MAX_WRITE_DATA = 16,
   parameter int  INITIAL_OPEN   = 0,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int NP_WIDTH       = $clog2(MAX_NON_POSTED + 1),
   localparam int WD_WIDTH       = $clog2(MAX_WRITE_DATA + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_open_request,
   input  logic                i_close_request,
   input  logic                i_command_ack,
   input  logic                i_command_non_posted,
   input  logic                i_command_with_data,
   input  logic                i_write_data_last_ack,
   input  logic                i_response_last_ack,
   output logic                o_enable,
   output logic                o_command_block,
   output logic                o_busy,
   output logic                o_done,
   output logic [NP_WIDTH-1:0] o_np_count,
   output logic [WD_WIDTH-1:0] o_wd_count,
   output logic                o_violation,
   output logic                o_timeout
);

   typedef enum logic [1:0] {
      S_CLOSED = 2'd0,
      S_OPEN   = 2'd1,
      S_DRAIN  = 2'd2,
      S_SWITCH = 2'd3
   } state_t;

   localparam logic [NP_WIDTH-1:0] c_NP_MAX    = NP_WIDTH'(MAX_NON_POSTED);
   localparam logic [WD_WIDTH-1:0] c_WD_MAX    = WD_WIDTH'(MAX_WRITE_DATA);
   localparam logic                c_INIT_OPEN = (INITIAL_OPEN != 0);

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t              r_state;
   logic                r_target;
   logic                r_enable;
   logic                r_command_block;
   logic                r_busy;
   logic                r_done;
   logic                r_violation;
   logic [NP_WIDTH-1:0] r_np_count;
   logic [WD_WIDTH-1:0] r_wd_count;
   logic [NP_WIDTH-1:0] w_np_next;
   logic [WD_WIDTH-1:0] w_wd_next;
   logic                w_np_inc, w_np_dec, w_wd_inc, w_wd_dec;
   logic                w_drained, w_sat_next, w_req, w_req_target;
   logic                w_violation_now, w_timeout_fire;

   assign w_np_inc     = i_command_ack & i_command_non_posted;
   assign w_np_dec     = i_response_last_ack;
   assign w_wd_inc     = i_command_ack & i_command_with_data;
   assign w_wd_dec     = i_write_data_last_ack;
   assign w_drained    = (r_np_count == '0) && (r_wd_count == '0);
   assign w_req        = i_open_request | i_close_request;
   assign w_req_target = ~i_close_request;

   // Saturating counters; a simultaneous increment and decrement cancel out.
   always_comb begin
      w_np_next = r_np_count;
      if (w_np_inc && !w_np_dec && (r_np_count != c_NP_MAX))
         w_np_next = r_np_count + NP_WIDTH'(1);
      else if (w_np_dec && !w_np_inc && (r_np_count != '0))
         w_np_next = r_np_count - NP_WIDTH'(1);
      w_wd_next = r_wd_count;
      if (w_wd_inc && !w_wd_dec && (r_wd_count != c_WD_MAX))
         w_wd_next = r_wd_count + WD_WIDTH'(1);
      else if (w_wd_dec && !w_wd_inc && (r_wd_count != '0))
         w_wd_next = r_wd_count - WD_WIDTH'(1);
   end

   assign w_sat_next      = (w_np_next == c_NP_MAX) || (w_wd_next == c_WD_MAX);
   assign w_violation_now = (w_np_inc && !w_np_dec && (r_np_count == c_NP_MAX))
                          | (w_np_dec && !w_np_inc && (r_np_count == '0))
                          | (w_wd_inc && !w_wd_dec && (r_wd_count == c_WD_MAX))
                          | (w_wd_dec && !w_wd_inc && (r_wd_count == '0))
                          | (i_command_ack && r_command_block);

`ifdef PZCOREBUS_GATE_CONTROLLER_TIMEOUT_EN
   localparam int c_TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_TO_WIDTH-1:0] r_drain_cnt;
   logic                  r_timeout;

   assign w_timeout_fire = (r_state == S_DRAIN) && !w_drained
                        && (r_drain_cnt == c_TO_WIDTH'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drain_cnt <= '0;
         r_timeout   <= 1'b0;
      end else begin
         if (((r_state == S_CLOSED) || (r_state == S_OPEN)) && w_req) begin
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
         end else if ((r_state == S_DRAIN) && !w_timeout_fire) begin
            r_drain_cnt <= r_drain_cnt + c_TO_WIDTH'(1);
         end
         if (w_timeout_fire)
            r_timeout <= 1'b1;
      end
   end

   assign o_timeout = r_timeout;
`else
   assign w_timeout_fire = 1'b0;
   assign o_timeout      = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_np_count  <= '0;
         r_wd_count  <= '0;
         r_violation <= 1'b0;
      end else begin
         r_np_count  <= w_timeout_fire ? '0 : w_np_next;
         r_wd_count  <= w_timeout_fire ? '0 : w_wd_next;
         r_violation <= r_violation | w_violation_now;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= c_INIT_OPEN ? S_OPEN : S_CLOSED;
         r_target        <= c_INIT_OPEN;
         r_enable        <= c_INIT_OPEN;
         r_command_block <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_CLOSED, S_OPEN: begin
               r_busy          <= 1'b0;
               r_command_block <= w_sat_next;
               if (w_req) begin
                  // In an idle state the enable mirrors the current state.
                  if (w_req_target == r_enable) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state         <= S_DRAIN;
                     r_target        <= w_req_target;
                     r_busy          <= 1'b1;
                     r_command_block <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               r_busy          <= 1'b1;
               r_command_block <= 1'b1;
               if (w_drained || w_timeout_fire)
                  r_state <= S_SWITCH;
            end
            default: begin
               r_state         <= r_target ? S_OPEN : S_CLOSED;
               r_enable        <= r_target;
               r_done          <= 1'b1;
               r_busy          <= 1'b0;
               r_command_block <= w_sat_next;
            end
         endcase
      end
   end

   assign o_enable        = r_enable;
   assign o_command_block = r_command_block;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_np_count      = r_np_count;
   assign o_wd_count      = r_wd_count;
   assign o_violation     = r_violation;

endmodule
`default_nettype wire

// File: tb/tb_pzcorebus_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pzcorebus_gate_controller
// Purpose  : Directed vector table plus hand sequences for the gate controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pzcorebus_gate_controller;

   logic       clk = 1'b0;
   logic       rst, op, cl, ack, npst, wdat, wdl, rsl;
   logic       en0, blk0, busy0, done0, viol0, to0;
   logic       en1, blk1, busy1, done1, viol1, to1;
   logic [4:0] np0, wd0, np1, wd1;
   int         n_checks = 0;
   int         n_err    = 0;

   always #5 clk = ~clk;

   pzcorebus_gate_controller #(
      .MAX_NON_POSTED(16), .MAX_WRITE_DATA(16), .INITIAL_OPEN(0), .TIMEOUT_CYCLES(8)
   ) dut0 (
      .i_clk(clk), .i_rst(rst), .i_open_request(op), .i_close_request(cl),
      .i_command_ack(ack), .i_command_non_posted(npst), .i_command_with_data(wdat),
      .i_write_data_last_ack(wdl), .i_response_last_ack(rsl),
      .o_enable(en0), .o_command_block(blk0), .o_busy(busy0), .o_done(done0),
      .o_np_count(np0), .o_wd_count(wd0), .o_violation(viol0), .o_timeout(to0)
   );

   pzcorebus_gate_controller #(
      .MAX_NON_POSTED(16), .MAX_WRITE_DATA(16), .INITIAL_OPEN(1), .TIMEOUT_CYCLES(8)
   ) dut1 (
      .i_clk(clk), .i_rst(rst), .i_open_request(op), .i_close_request(cl),
      .i_command_ack(ack), .i_command_non_posted(npst), .i_command_with_data(wdat),
      .i_write_data_last_ack(wdl), .i_response_last_ack(rsl),
      .o_enable(en1), .o_command_block(blk1), .o_busy(busy1), .o_done(done1),
      .o_np_count(np1), .o_wd_count(wd1), .o_violation(viol1), .o_timeout(to1)
   );

   // inputs = {open, close, ack, non_posted, with_data, wdata_last, resp_last}
   // ctl    = {enable, block, busy, done}
   typedef struct packed {
      logic [6:0] inputs;
      logic [3:0] ctl;
      logic [4:0] npc;
      logic [4:0] wdc;
      logic       viol;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(logic [6:0] in, logic [3:0] ctl, int npc, int wdc, logic viol);
      vec_t v;
      v.inputs = in;
      v.ctl    = ctl;
      v.npc    = 5'(npc);
      v.wdc    = 5'(wdc);
      v.viol   = viol;
      return v;
   endfunction

   task automatic drive(input logic [6:0] v);
      {op, cl, ack, npst, wdat, wdl, rsl} = v;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      drive(7'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(7'b0);

      vecs[0]  = mk(7'b1000000, 4'b0110, 0, 0, 1'b0); // open from closed: drain
      vecs[1]  = mk(7'b0000000, 4'b0110, 0, 0, 1'b0); // switch
      vecs[2]  = mk(7'b0000000, 4'b1001, 0, 0, 1'b0); // open + done
      vecs[3]  = mk(7'b0000000, 4'b1000, 0, 0, 1'b0);
      vecs[4]  = mk(7'b0011000, 4'b1000, 1, 0, 1'b0);
      vecs[5]  = mk(7'b0011100, 4'b1000, 2, 1, 1'b0);
      vecs[6]  = mk(7'b0011001, 4'b1000, 2, 1, 1'b0); // simultaneous inc/dec
      vecs[7]  = mk(7'b0000010, 4'b1000, 2, 0, 1'b0);
      vecs[8]  = mk(7'b0000001, 4'b1000, 1, 0, 1'b0);
      vecs[9]  = mk(7'b1000000, 4'b1001, 1, 0, 1'b0); // open while open
      vecs[10] = mk(7'b0000000, 4'b1000, 1, 0, 1'b0);
      vecs[11] = mk(7'b0100000, 4'b1110, 1, 0, 1'b0); // close: drain
      vecs[12] = mk(7'b1000000, 4'b1110, 1, 0, 1'b0); // open ignored
      vecs[13] = mk(7'b0000000, 4'b1110, 1, 0, 1'b0);
      vecs[14] = mk(7'b0000001, 4'b1110, 0, 0, 1'b0);
      vecs[15] = mk(7'b0000000, 4'b1110, 0, 0, 1'b0); // switch
      vecs[16] = mk(7'b0000000, 4'b0001, 0, 0, 1'b0); // closed + done
      vecs[17] = mk(7'b1100000, 4'b0001, 0, 0, 1'b0); // both: close wins
      vecs[18] = mk(7'b0000000, 4'b0000, 0, 0, 1'b0);
      vecs[19] = mk(7'b0000001, 4'b0000, 0, 0, 1'b1); // response at zero
      vecs[20] = mk(7'b0000010, 4'b0000, 0, 0, 1'b1);

      // Reset values for both INITIAL_OPEN settings
      tick();
      tick();
      check("reset0_ctl", {28'd0, en0, blk0, busy0, done0}, 32'h0);
      check("reset0_cnt", {22'd0, np0, wd0}, 32'h0);
      check("reset0_flags", {30'd0, viol0, to0}, 32'h0);
      check("reset1_ctl", {28'd0, en1, blk1, busy1, done1}, 32'h8);
      check("reset1_cnt", {22'd0, np1, wd1}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].inputs);
         tick();
         check($sformatf("vec%0d_ctl", i), {28'd0, en0, blk0, busy0, done0}, {28'd0, vecs[i].ctl});
         check($sformatf("vec%0d_np", i), {27'd0, np0}, {27'd0, vecs[i].npc});
         check($sformatf("vec%0d_wd", i), {27'd0, wd0}, {27'd0, vecs[i].wdc});
         check($sformatf("vec%0d_viol", i), {31'd0, viol0}, {31'd0, vecs[i].viol});
      end
      drive(7'b0);

      // Saturation at MAX_NON_POSTED
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(7'b0011000);
         tick();
      end
      check("sat_np16", {27'd0, np0}, 32'd16);
      check("sat_block", {31'd0, blk0}, 32'd1);
      check("sat_noviol", {31'd0, viol0}, 32'd0);
      drive(7'b0011000);
      tick();
      drive(7'b0);
      check("sat_np_hold", {27'd0, np0}, 32'd16);
      check("sat_viol", {31'd0, viol0}, 32'd1);

      // Ack while blocked in drain, then reset mid-drain
      do_reset();
      drive(7'b1000000);
      tick();
      check("blk_drain", {30'd0, blk0, busy0}, 32'h3);
      drive(7'b0010000);
      tick();
      check("blk_ack_viol", {31'd0, viol0}, 32'd1);
      drive(7'b0);
      rst = 1'b1;
      tick();
      check("mid_rst", {26'd0, en0, blk0, busy0, done0, viol0, to0}, 32'h0);
      rst = 1'b0;
      tick();
      tick();
      check("mid_rst_nodone", {29'd0, en0, busy0, done0}, 32'h0);

      // Close from open with three outstanding responses returned late
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(7'b0011000);
         tick();
      end
      check("drain_np3", {27'd0, np1}, 32'd3);
      drive(7'b0100000);
      tick();
      check("drain_entry", {29'd0, en1, blk1, busy1}, 32'h7);
      for (int k = 1; k <= 10; k++) begin
         logic [4:0] exp_np;
         drive((k >= 5 && k <= 7) ? 7'b0000001 : 7'b0);
         tick();
         exp_np = (k < 5) ? 5'd3 : ((k < 8) ? 5'(7 - k) : 5'd0);
         check($sformatf("drain_k%0d_np", k), {27'd0, np1}, {27'd0, exp_np});
         check($sformatf("drain_k%0d_ctl", k), {29'd0, en1, blk1, done1},
               {29'd0, (k <= 8), (k <= 8), (k == 9)});
      end
      drive(7'b0);

`ifdef PZCOREBUS_GATE_CONTROLLER_TIMEOUT_EN
      // Drain timeout with one response never returned
      do_reset();
      drive(7'b1000000);
      tick();
      drive(7'b0);
      tick();
      tick();
      drive(7'b0011000);
      tick();
      drive(7'b0100000);
      tick();
      drive(7'b0);
      for (int k = 1; k <= 9; k++) begin
         tick();
         check($sformatf("to_k%0d", k), {24'd0, np0, to0, en0, done0},
               {24'd0, (k < 8) ? 5'd1 : 5'd0, (k >= 8), (k <= 8), (k == 9)});
      end
      drive(7'b1000000);
      tick();
      drive(7'b0);
      check("to_clear", {31'd0, to0}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
